tdm_demux41: RTL and testbench

- Receive-side counterpart of the team's 4:1 channel multiplexing: takes a time-division-multiplexed stream of 4 slots per frame and distributes it onto 4 registered parallel channel outputs.
- Locks onto a slot-0 sync marker, tracks slot position with a counter, and publishes a complete frame atomically with a one-cycle frame_valid strobe.
- Sits between a serial/TDM link and per-channel consumers.

---
 rtl/tdm_demux41.sv | 146 ++++++++++++++
 tb/tb_tdm_demux41.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux41.sv
// TDM receive demultiplexer: 4 slots per frame onto 4 registered channel outputs.
// Locks on a slot-0 sync marker, collects slots 0..2 in shadow registers and
// publishes the whole frame atomically on the slot-3 beat with a frame_valid strobe.
module tdm_demux41 #(
  parameter int unsigned WIDTH            = 1,
  parameter bit          SYNC_EVERY_FRAME = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  state_e           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] sh0_q, sh0_d;
  logic [WIDTH-1:0] sh1_q, sh1_d;
  logic [WIDTH-1:0] sh2_q, sh2_d;
  logic [WIDTH-1:0] q0_q, q0_d;
  logic [WIDTH-1:0] q1_q, q1_d;
  logic [WIDTH-1:0] q2_q, q2_d;
  logic [WIDTH-1:0] q3_q, q3_d;
  logic             frame_valid_q, frame_valid_d;
  logic             sync_err_q, sync_err_d;

  // Next-state: slot tracking, shadow capture and atomic frame publish
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    sh0_d         = sh0_q;
    sh1_d         = sh1_q;
    sh2_d         = sh2_q;
    q0_d          = q0_q;
    q1_d          = q1_q;
    q2_d          = q2_q;
    q3_d          = q3_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        StHunt: begin
          // Non-sync beats are dropped until a slot-0 marker arrives
          if (sync) begin
            sh0_d   = din;
            slot_d  = 2'd1;
            state_d = StLocked;
          end
        end

        StLocked: begin
          if (sync) begin
            // A marker always restarts the frame; mid-frame it also flags an error
            sync_err_d = (slot_q != 2'd0);
            sh0_d      = din;
            slot_d     = 2'd1;
          end else begin
            unique case (slot_q)
              2'd0: begin
                if (SYNC_EVERY_FRAME) begin
                  sync_err_d = 1'b1;
                  slot_d     = 2'd0;
                  state_d    = StHunt;
                end else begin
                  sh0_d  = din;
                  slot_d = 2'd1;
                end
              end
              2'd1: begin
                sh1_d  = din;
                slot_d = 2'd2;
              end
              2'd2: begin
                sh2_d  = din;
                slot_d = 2'd3;
              end
              2'd3: begin
                // Slot 3 goes straight to q3 so the frame lands in one edge
                q0_d          = sh0_q;
                q1_d          = sh1_q;
                q2_d          = sh2_q;
                q3_d          = din;
                frame_valid_d = 1'b1;
                slot_d        = 2'd0;
              end
              default: slot_d = 2'd0;
            endcase
          end
        end

        default: begin
          state_d = StHunt;
          slot_d  = 2'd0;
        end
      endcase
    end
  end

  // State, shadow and output registers; reset discards any partial frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StHunt;
      slot_q        <= 2'd0;
      sh0_q         <= '0;
      sh1_q         <= '0;
      sh2_q         <= '0;
      q0_q          <= '0;
      q1_q          <= '0;
      q2_q          <= '0;
      q3_q          <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      sh0_q         <= sh0_d;
      sh1_q         <= sh1_d;
      sh2_q         <= sh2_d;
      q0_q          <= q0_d;
      q1_q          <= q1_d;
      q2_q          <= q2_d;
      q3_q          <= q3_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign q0          = q0_q;
  assign q1          = q1_q;
  assign q2          = q2_q;
  assign q3          = q3_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == StLocked);

endmodule

// File: tb/tb_tdm_demux41.sv
// Bench for tdm_demux41: two instances (sync required every frame / only to lock)
// share one stimulus stream; a sample-collecting model feeds per-instance
// expectation queues that a negedge monitor drains when the DUT strobes.
module tb_tdm_demux41;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic [31:0]  edge_no;
    logic         is_err;
    logic [W-1:0] f0;
    logic [W-1:0] f1;
    logic [W-1:0] f2;
    logic [W-1:0] f3;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] din;
  logic         din_valid;
  logic         sync;
  logic         done;

  logic [W-1:0] a_q0, a_q1, a_q2, a_q3;
  logic         a_fv, a_lk, a_se;
  logic [W-1:0] b_q0, b_q1, b_q2, b_q3;
  logic         b_fv, b_lk, b_se;

  int unsigned  edge_cnt;
  int unsigned  n_cmp;
  int unsigned  n_bad;
  exp_t         qa[$];
  exp_t         qb[$];

  // Reference model: collected samples of the frame in progress per instance
  bit           m_locked[2];
  int           m_n[2];
  logic [W-1:0] m_s[2][3];
  logic [W-1:0] hf[2][4];

  tdm_demux41 #(.WIDTH(W), .SYNC_EVERY_FRAME(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
    .q0(a_q0), .q1(a_q1), .q2(a_q2), .q3(a_q3),
    .frame_valid(a_fv), .locked(a_lk), .sync_err(a_se)
  );

  tdm_demux41 #(.WIDTH(W), .SYNC_EVERY_FRAME(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
    .q0(b_q0), .q1(b_q1), .q2(b_q2), .q3(b_q3),
    .frame_valid(b_fv), .locked(b_lk), .sync_err(b_se)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  function automatic void push_exp(input int k, input logic is_err, input logic [W-1:0] f0,
                                   input logic [W-1:0] f1, input logic [W-1:0] f2,
                                   input logic [W-1:0] f3);
    exp_t e;
    e.edge_no = edge_cnt + 1;
    e.is_err  = is_err;
    e.f0 = f0; e.f1 = f1; e.f2 = f2; e.f3 = f3;
    if (k == 0) qa.push_back(e);
    else qb.push_back(e);
  endfunction

  function automatic void model_step(input int k, input bit sef);
    if (!din_valid) return;
    if (!m_locked[k]) begin
      if (sync) begin
        m_locked[k] = 1'b1;
        m_s[k][0]   = din;
        m_n[k]      = 1;
      end
    end else if (sync) begin
      if (m_n[k] != 0) push_exp(k, 1'b1, '0, '0, '0, '0);
      m_s[k][0] = din;
      m_n[k]    = 1;
    end else if (m_n[k] == 0) begin
      if (sef) begin
        push_exp(k, 1'b1, '0, '0, '0, '0);
        m_locked[k] = 1'b0;
      end else begin
        m_s[k][0] = din;
        m_n[k]    = 1;
      end
    end else if (m_n[k] == 3) begin
      push_exp(k, 1'b0, m_s[k][0], m_s[k][1], m_s[k][2], din);
      m_n[k] = 0;
    end else begin
      m_s[k][m_n[k]] = din;
      m_n[k]         = m_n[k] + 1;
    end
  endfunction

  // Model advances on every clock edge out of reset
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 2; k++) begin
          m_locked[k] = 1'b0;
          m_n[k]      = 0;
        end
      end else begin
        model_step(0, 1'b1);
        model_step(1, 1'b0);
        edge_cnt = edge_cnt + 1;
      end
    end
  end

  function automatic void check(input string name, input int k, input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s dut%0d @edge %0d: got %0h, expected %0h", name, k, edge_cnt, act, exp);
    end
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? qa.size() : qb.size();
  endfunction

  function automatic exp_t qfront(input int k);
    return (k == 0) ? qa[0] : qb[0];
  endfunction

  function automatic exp_t qpop(input int k);
    return (k == 0) ? qa.pop_front() : qb.pop_front();
  endfunction

  task automatic mon(input int k, input logic [W-1:0] o0, input logic [W-1:0] o1,
                     input logic [W-1:0] o2, input logic [W-1:0] o3,
                     input logic fv, input logic lk, input logic se);
    exp_t e;
    while (qsize(k) > 0 && qfront(k).edge_no < edge_cnt) begin
      e = qpop(k);
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL missed_%s dut%0d: expected at edge %0d, not seen by edge %0d",
               e.is_err ? "sync_err" : "frame", k, e.edge_no, edge_cnt);
    end
    if (fv || se) begin
      if (qsize(k) == 0) begin
        n_cmp = n_cmp + 1;
        n_bad = n_bad + 1;
        $display("FAIL unexpected_event dut%0d @edge %0d: got fv=%0b se=%0b, expected none",
                 k, edge_cnt, fv, se);
      end else begin
        e = qpop(k);
        check("event_edge", k, edge_cnt, e.edge_no);
        check("event_kind", k, {fv, se}, e.is_err ? 32'd1 : 32'd2);
        if (!e.is_err) begin
          hf[k][0] = e.f0; hf[k][1] = e.f1; hf[k][2] = e.f2; hf[k][3] = e.f3;
        end
      end
    end
    check("q0", k, o0, hf[k][0]);
    check("q1", k, o1, hf[k][1]);
    check("q2", k, o2, hf[k][2]);
    check("q3", k, o3, hf[k][3]);
    check("locked", k, lk, m_locked[k]);
    check("fv_se_exclusive", k, fv & se, 0);
  endtask

  task automatic rst_chk(input int k, input logic [W-1:0] o0, input logic [W-1:0] o1,
                         input logic [W-1:0] o2, input logic [W-1:0] o3,
                         input logic fv, input logic lk, input logic se);
    check("rst_q0", k, o0, 0);
    check("rst_q1", k, o1, 0);
    check("rst_q2", k, o2, 0);
    check("rst_q3", k, o3, 0);
    check("rst_frame_valid", k, fv, 0);
    check("rst_locked", k, lk, 0);
    check("rst_sync_err", k, se, 0);
    for (int i = 0; i < 4; i++) hf[k][i] = '0;
  endtask

  // Monitor: samples 1 time unit after each falling clock or reset assertion
  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int k = 0; k < 2; k++) for (int i = 0; i < 4; i++) hf[k][i] = '0;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      if (!rst_n) begin
        rst_chk(0, a_q0, a_q1, a_q2, a_q3, a_fv, a_lk, a_se);
        rst_chk(1, b_q0, b_q1, b_q2, b_q3, b_fv, b_lk, b_se);
      end else begin
        mon(0, a_q0, a_q1, a_q2, a_q3, a_fv, a_lk, a_se);
        mon(1, b_q0, b_q1, b_q2, b_q3, b_fv, b_lk, b_se);
      end
      if (done) begin
        check("pending_expectations", 0, qa.size(), 0);
        check("pending_expectations", 1, qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  end

  task automatic beat(input logic v, input logic s, input logic [W-1:0] d);
    @(negedge clk);
    din_valid = v;
    sync      = s;
    din       = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, '0);
  endtask

  task automatic frame(input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic [W-1:0] d2, input logic [W-1:0] d3);
    beat(1'b1, 1'b1, d0);
    beat(1'b1, 1'b0, d1);
    beat(1'b1, 1'b0, d2);
    beat(1'b1, 1'b0, d3);
  endtask

  // Stimulus
  initial begin
    int p;
    logic v;
    logic s;
    rst_n     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    sync      = 1'b0;
    done      = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Unsynced beats while hunting are ignored, then a clean 1,0,1,1 frame
    beat(1'b1, 1'b0, 4'h1);
    beat(1'b1, 1'b0, 4'h1);
    frame(4'h1, 4'h0, 4'h1, 4'h1);
    idle(2);

    // Same frame with a 3-cycle valid gap between slot 1 and slot 2
    beat(1'b1, 1'b1, 4'h1);
    beat(1'b1, 1'b0, 4'h0);
    idle(3);
    beat(1'b1, 1'b0, 4'h1);
    beat(1'b1, 1'b0, 4'h1);

    // Early sync on slot 2 restarts the frame with q0 = 1
    beat(1'b1, 1'b1, 4'h0);
    beat(1'b1, 1'b0, 4'h1);
    beat(1'b1, 1'b1, 4'h1);
    beat(1'b1, 1'b0, 4'h0);
    beat(1'b1, 1'b0, 4'h1);
    beat(1'b1, 1'b0, 4'h0);

    // Slot-0 beat without sync: error and unlock vs. accepted frame
    beat(1'b1, 1'b0, 4'h5);
    beat(1'b1, 1'b0, 4'ha);
    beat(1'b1, 1'b0, 4'h3);
    beat(1'b1, 1'b0, 4'hc);
    frame(4'h2, 4'h3, 4'h4, 4'h5);

    // Asynchronous reset after slot 2, then a clean frame
    beat(1'b1, 1'b1, 4'h6);
    beat(1'b1, 1'b0, 4'h7);
    beat(1'b1, 1'b0, 4'h8);
    @(negedge clk);
    #2;
    rst_n     = 1'b0;
    din_valid = 1'b0;
    sync      = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    frame(4'h9, 4'ha, 4'hb, 4'hc);
    idle(1);

    // Random traffic: mostly well-framed, occasional sync faults and gaps
    p = 0;
    for (int i = 0; i < 800; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = 1'b0;
      if (v) begin
        s = (p == 0) ^ ($urandom_range(0, 15) == 0);
        p = (p + 1) % 4;
      end
      beat(v, s, W'($urandom));
    end
    idle(4);
    done = 1'b1;
    forever @(negedge clk);
  end

endmodule
